serial_subtractor: RTL and testbench

Bit-serial, LSB-first subtractor that computes DIFF = A - B.
- Mirror of the team's combinational full-adder cell: one full-subtractor slice plus a borrow flip-flop, iterated WIDTH times.
- Sits beside the ALU datapath in lab designs where area matters more than latency.
- Driven by a start/busy/done handshake from a controlling FSM.

---
 rtl/serial_subtractor.sv | 175 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first subtractor computing diff = a - b.
// One full-subtractor slice plus a borrow flop, iterated WIDTH times,
// controlled by a start/busy/done handshake.
//
// Optional feature macro: SERIAL_SUB_FLAGS_EN (adds zero and ovf outputs).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   a, b       minuend / subtrahend, captured on accepted start
//   busy       high while in SHIFT or DONE
//   done       single-cycle pulse, diff/borrow_out valid
//   diff       a - b modulo 2^WIDTH, held until the next done
//   borrow_out 1 when a < b (unsigned)
//   zero, ovf  (SERIAL_SUB_FLAGS_EN only) diff == 0, signed overflow
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sa, sa_d;
  logic [WIDTH-1:0] sb, sb_d;
  logic [WIDTH-1:0] res, res_d;
  logic             borrow, borrow_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             busy_d, done_d;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_out_d;

  // Full-subtractor slice on the current LSBs
  logic             bit_d;
  logic             bit_borrow;
  logic [WIDTH-1:0] res_shift;

  assign bit_d      = sa[0] ^ sb[0] ^ borrow;
  assign bit_borrow = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
  assign res_shift  = {bit_d, res[WIDTH-1:1]};

`ifdef SERIAL_SUB_FLAGS_EN
  // Operand MSBs kept separately since sa/sb are shifted away
  logic a_msb, a_msb_d;
  logic b_msb, b_msb_d;
  logic zero_d, ovf_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      sa         <= sa_d;
      sb         <= sb_d;
      res        <= res_d;
      borrow     <= borrow_d;
      cnt        <= cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      diff       <= diff_d;
      borrow_out <= borrow_out_d;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb      <= a_msb_d;
      b_msb      <= b_msb_d;
      zero       <= zero_d;
      ovf        <= ovf_d;
`endif
    end
  end

  // Next-state and next-output logic; busy_d/done_d describe the next state
  always_comb begin
    state_d      = state;
    sa_d         = sa;
    sb_d         = sb;
    res_d        = res;
    borrow_d     = borrow;
    cnt_d        = cnt;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    diff_d       = diff;
    borrow_out_d = borrow_out;
`ifdef SERIAL_SUB_FLAGS_EN
    a_msb_d      = a_msb;
    b_msb_d      = b_msb;
    zero_d       = zero;
    ovf_d        = ovf;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
`ifdef SERIAL_SUB_FLAGS_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end

      SHIFT: begin
        busy_d   = 1'b1;
        sa_d     = sa >> 1;
        sb_d     = sb >> 1;
        res_d    = res_shift;
        borrow_d = bit_borrow;
        cnt_d    = cnt + CNT_W'(1);
        if (cnt == LAST_BIT) begin
          state_d      = DONE;
          done_d       = 1'b1;
          diff_d       = res_shift;
          borrow_out_d = bit_borrow;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_d       = (res_shift == '0);
          ovf_d        = (a_msb != b_msb) && (res_shift[WIDTH-1] != a_msb);
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8). Expected results are
// pushed to a scoreboard queue when a start is driven and popped on done.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  logic [W-1:0] last_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (op_a),
    .b          (op_b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero       (zero),
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.diff   = W'(x - y);
    e.borrow = (x < y);
    e.zero   = (e.diff == '0);
    e.ovf    = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called #1 after a reference edge; waits for done, expecting it after
  // exactly exp_lat further edges. Optionally checks diff holds meanwhile.
  task automatic wait_done(input int exp_lat, input logic hold_en,
                           input logic [W-1:0] hold_val, input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!done && hold_en) check({tag, "_diff_hold"}, 32'(diff), 32'(hold_val));
    end while (!done && lat < 40);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (done) begin
      check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
      if (sb_q.size() == 0) begin
        check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check({tag, "_diff"}, 32'(diff), 32'(e.diff));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(e.borrow));
`ifdef SERIAL_SUB_FLAGS_EN
        check({tag, "_zero"}, 32'(zero), 32'(e.zero));
        check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
        last_diff = e.diff;
      end
    end
  endtask

  // Single operation: one-cycle start pulse, then wait for the result
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    @(negedge clk);
    op_a  = x;
    op_b  = y;
    start = 1'b1;
    sb_q.push_back(model(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_done_low_after_start"}, 32'(done), 32'd0);
    wait_done(W, 1'b1, last_diff, tag);
    @(posedge clk);
    #1;
    check({tag, "_done_single"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_diff_after"}, 32'(diff), 32'(last_diff));
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h35, 8'h12, "op35_12");
    run_op(8'h12, 8'h35, "op12_35");
    run_op(8'h00, 8'h01, "op00_01");

    // Abort in the middle of SHIFT; outputs clear without a clock edge
    @(negedge clk);
    op_a  = 8'h35;
    op_b  = 8'h12;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_borrow", 32'(borrow_out), 32'd0);
    last_diff = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    run_op(8'h20, 8'h01, "op20_01");
    run_op(8'hFF, 8'hFF, "opFF_FF");

    // Start and operand changes during SHIFT are ignored
    @(negedge clk);
    op_a  = 8'h10;
    op_b  = 8'h01;
    start = 1'b1;
    sb_q.push_back(model(8'h10, 8'h01));
    @(posedge clk);
    #1;
    op_a = 8'h99;
    op_b = 8'h11;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(W - 3, 1'b1, last_diff, "ignore");
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("ignore_no_second", 32'(pulses), 32'd0);
    check("ignore_idle", 32'(busy), 32'd0);
    check("ignore_diff_hold", 32'(diff), 32'h0F);

    // Back-to-back with start held high: one result every W+2 cycles
    @(negedge clk);
    op_a  = 8'h05;
    op_b  = 8'h03;
    start = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back(model(8'h05, 8'h03));
    @(posedge clk);
    #1;
    wait_done(W, 1'b1, last_diff, "b2b0");
    wait_done(W + 2, 1'b1, 8'h02, "b2b1");
    wait_done(W + 2, 1'b1, 8'h02, "b2b2");
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("b2b_stopped", 32'(busy), 32'd0);

    run_op(8'h80, 8'h01, "op80_01");
    run_op(8'h42, 8'h42, "op42_42");
    run_op(8'h7F, 8'hFF, "op7F_FF");
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), "rand");
    end

    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
